// File: rtl/mem_access_unit.sv
// Initiator for a byte-wide, little-endian data memory: splits one 8/16-bit
// load/store from the MEM stage into one or two byte transactions with wait states.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  // The abort fires on the wait cycle that brings the counter up to TIMEOUT.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        is_write;
  logic        is_byte;
  logic        is_signed;
  logic        err;
  logic [7:0]  wait_cnt;

  function automatic logic [15:0] byte_ext(input logic [7:0] b, input logic sgn);
    return {{8{b[7] & sgn}}, b};
  endfunction

  // Outputs are registered, so each transition also loads the strobes and
  // response fields that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      wdata      <= '0;
      rdata      <= '0;
      is_write   <= 1'b0;
      is_byte    <= 1'b0;
      is_signed  <= 1'b0;
      err        <= 1'b0;
      wait_cnt   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      stall      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr       <= req_addr;
            wdata      <= req_wdata;
            is_write   <= req_write;
            is_byte    <= req_byte;
            is_signed  <= req_signed;
            rdata      <= '0;
            err        <= 1'b0;
            wait_cnt   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b0;
            stall      <= 1'b1;
            mem_addr   <= req_addr;
            mem_wdata  <= req_wdata[7:0];
            mem_we     <= req_write;
            mem_re     <= ~req_write;
            state      <= LO;
          end
        end
        LO: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            if (!is_write) rdata[7:0] <= mem_rdata;
            if (is_byte) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= is_write ? 16'h0000 : byte_ext(mem_rdata, is_signed);
              mem_we     <= 1'b0;
              mem_re     <= 1'b0;
            end else begin
              state     <= HI;
              mem_addr  <= addr + 16'd1;
              mem_wdata <= wdata[15:8];
            end
          end else if (wait_cnt == LIMIT) begin
            wait_cnt   <= wait_cnt + 8'd1;
            err        <= 1'b1;
            rdata      <= '0;
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HI: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            if (!is_write) rdata[15:8] <= mem_rdata;
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= is_write ? 16'h0000 : {mem_rdata, rdata[7:0]};
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
          end else if (wait_cnt == LIMIT) begin
            wait_cnt   <= wait_cnt + 8'd1;
            err        <= 1'b1;
            rdata      <= '0;
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          stall     <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single requests against a byte
// memory model, plus hand-written wait-state, timeout and reset sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        ready_en;

  logic [7:0]  mem [0:65535];
  int          rd_count = 0;
  int          wr_count = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic        write;
    logic        is_byte;
    logic        sgn;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Byte memory: combinational read, write and transaction counting on completion.
  assign mem_ready = (mem_we | mem_re) & ready_en;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_ready) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wr_count <= wr_count + 1;
      end
      if (mem_re) rd_count <= rd_count + 1;
    end
  end

  function automatic void check_output(input string name, input logic [31:0] act,
                                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic drive_req(input vec_t v);
    req_write  = v.write;
    req_byte   = v.is_byte;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // One request with zero-wait memory: checks latency, data, error and transaction counts.
  task automatic apply_stimulus(input vec_t v, input string name);
    int rd0;
    int wr0;
    int lat;
    bit seen;
    @(negedge clk);
    check_output({name, "_ready"}, req_ready, 1);
    rd0 = rd_count;
    wr0 = wr_count;
    drive_req(v);
    seen = 0;
    lat = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1;
        lat = k;
      end
    end
    check_output({name, "_resp_seen"}, seen, 1);
    if (seen) begin
      check_output({name, "_latency"}, lat, v.is_byte ? 2 : 3);
      check_output({name, "_rdata"}, resp_rdata, v.exp);
      check_output({name, "_err"}, resp_err, 0);
      check_output({name, "_reads"}, rd_count - rd0, v.write ? 0 : (v.is_byte ? 1 : 2));
      check_output({name, "_writes"}, wr_count - wr0, !v.write ? 0 : (v.is_byte ? 1 : 2));
    end
  endtask

  initial begin
    vec_t v;
    // write, byte, signed, addr, wdata, expected rdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0021, 16'h1285, 16'h0000};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000, 16'hFF85};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 16'h0085};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h1234, 16'h0000};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h1234};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 16'hFFBE};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0012};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF};

    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_byte = 1'b0;
    req_signed = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    ready_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_req_ready", req_ready, 1);
    check_output("rst_stall", stall, 0);
    check_output("rst_resp_valid", resp_valid, 0);
    check_output("rst_resp_rdata", resp_rdata, 0);
    check_output("rst_strobes", {mem_we, mem_re}, 0);
    check_output("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    check_output("mem_0010", mem[16'h0010], 8'hEF);
    check_output("mem_0011", mem[16'h0011], 8'hBE);
    check_output("mem_0021", mem[16'h0021], 8'h85);
    check_output("mem_ffff", mem[16'hFFFF], 8'h34);
    check_output("mem_0000", mem[16'h0000], 8'h12);

    // Wait states: three in LO, two in HI; response lands at accept+8.
    @(negedge clk);
    v = vecs[1];
    ready_en = 1'b0;
    drive_req(v);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      ready_en = (k == 4 || k == 7);
      if (k <= 4) begin
        check_output($sformatf("ws_lo_addr%0d", k), mem_addr, 16'h0010);
        check_output($sformatf("ws_lo_re%0d", k), {mem_re, mem_we}, 2'b10);
      end
      if (k >= 5 && k <= 7) begin
        check_output($sformatf("ws_hi_addr%0d", k), mem_addr, 16'h0011);
        check_output($sformatf("ws_hi_re%0d", k), mem_re, 1);
      end
      if (k == 7) check_output("ws_early_resp", resp_valid, 0);
      if (k == 8) begin
        check_output("ws_resp_valid", resp_valid, 1);
        check_output("ws_rdata", resp_rdata, 16'hBEEF);
        check_output("ws_err", resp_err, 0);
      end
    end
    ready_en = 1'b1;

    // Timeout: memory never answers, abort after four wait cycles in LO.
    @(negedge clk);
    ready_en = 1'b0;
    drive_req(v);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) check_output("to_early_resp", resp_valid, 0);
      if (k == 5) begin
        check_output("to_resp_valid", resp_valid, 1);
        check_output("to_err", resp_err, 1);
        check_output("to_rdata", resp_rdata, 0);
        check_output("to_strobes", {mem_we, mem_re}, 0);
      end
      if (k == 6) begin
        check_output("to_idle_stall", stall, 0);
        check_output("to_idle_ready", req_ready, 1);
      end
    end
    ready_en = 1'b1;
    apply_stimulus(vecs[4], "after_timeout");

    // Reset during the HI byte of a word store.
    @(negedge clk);
    v = '{1'b1, 1'b0, 1'b0, 16'h0030, 16'hAAAA, 16'h0000};
    drive_req(v);
    @(negedge clk);
    @(negedge clk);
    check_output("rs_hi_addr", mem_addr, 16'h0031);
    check_output("rs_hi_we", mem_we, 1);
    rst = 1'b1;
    ready_en = 1'b0;
    @(negedge clk);
    check_output("rs_we", mem_we, 0);
    check_output("rs_stall", stall, 0);
    check_output("rs_resp_valid", resp_valid, 0);
    check_output("rs_ready", req_ready, 1);
    rst = 1'b0;
    ready_en = 1'b1;
    apply_stimulus(vecs[3], "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
